// File: rtl/hs32_wb_bridge.sv
// hs32_wb_bridge: Wishbone classic responder that masters the hs32 internal bus.
// Define HS32_WB_RMW_EN to turn partial-select writes into read-modify-write cycles.
module hs32_wb_bridge #(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          WIN_BITS  = 24,
    parameter logic [7:0]  TIMEOUT   = 8'd255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_dat_i,
    input  logic [31:0] wbs_adr_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        req,
    input  logic        gnt,
    output logic [31:0] addr,
    output logic        rw,
    output logic [31:0] dtw,
    input  logic [31:0] dtr,
    output logic        stb,
    input  logic        ack,
    output logic        timeout_err
);
    typedef enum logic [2:0] {
        IDLE, WAIT_GNT, READ,
`ifdef HS32_WB_RMW_EN
        RMW_RD,
`endif
        WRITE, DONE
    } state_t;

    state_t      r_state, w_state;
    logic [31:0] r_addr, w_addr, r_wdat, w_wdat, r_dtw, w_dtw, r_rdat, w_rdat;
    logic [3:0]  r_sel, w_sel;
    logic        r_we, w_we, r_rw, w_rw, r_stb, w_stb, r_terr, w_terr;
    logic [7:0]  r_cnt, w_cnt, w_inc;
    logic        w_hit;
    logic        w_unused;

    assign w_unused = ^wbs_adr_i[1:0];
    assign w_hit = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:WIN_BITS] == BASE_ADDR[31:WIN_BITS]);

    always_comb begin
        w_state = r_state;
        w_addr  = r_addr;
        w_wdat  = r_wdat;
        w_sel   = r_sel;
        w_we    = r_we;
        w_rw    = r_rw;
        w_dtw   = r_dtw;
        w_stb   = 1'b0;
        w_cnt   = r_cnt;
        w_rdat  = r_rdat;
        w_terr  = r_terr;
        w_inc   = r_cnt + 8'd1;
        case (r_state)
            IDLE: if (w_hit) begin
                w_addr  = {{(32-WIN_BITS){1'b0}}, wbs_adr_i[WIN_BITS-1:2], 2'b00};
                w_wdat  = wbs_dat_i;
                w_sel   = wbs_sel_i;
                w_we    = wbs_we_i;
                w_state = WAIT_GNT;
            end
            WAIT_GNT: if (gnt) begin
                if (!r_we) begin
                    w_stb   = 1'b1;
                    w_rw    = 1'b0;
                    w_cnt   = 8'd0;
                    w_state = READ;
                end else if (r_sel == 4'hF) begin
                    w_stb   = 1'b1;
                    w_rw    = 1'b1;
                    w_dtw   = r_wdat;
                    w_cnt   = 8'd0;
                    w_state = WRITE;
`ifdef HS32_WB_RMW_EN
                end else if (r_sel != 4'h0) begin
                    w_stb   = 1'b1;
                    w_rw    = 1'b0;
                    w_cnt   = 8'd0;
                    w_state = RMW_RD;
`endif
                end else begin
                    w_state = DONE;
                end
            end
            DONE: w_state = IDLE;
            default: begin
                if (ack) begin
                    if (r_state == READ) begin
                        w_rdat  = dtr;
                        w_state = DONE;
`ifdef HS32_WB_RMW_EN
                    end else if (r_state == RMW_RD) begin
                        for (int i = 0; i < 4; i++)
                            w_dtw[8*i+:8] = r_sel[i] ? r_wdat[8*i+:8] : dtr[8*i+:8];
                        w_rw    = 1'b1;
                        w_stb   = 1'b1;
                        w_cnt   = 8'd0;
                        w_state = WRITE;
`endif
                    end else begin
                        w_state = DONE;
                    end
                end else begin
                    // Forced completion so a dead responder cannot hang the Wishbone master
                    w_cnt = w_inc;
                    if (w_inc == TIMEOUT) begin
                        w_rdat  = 32'hFFFF_FFFF;
                        w_terr  = 1'b1;
                        w_state = DONE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_addr  <= '0;
            r_wdat  <= '0;
            r_sel   <= '0;
            r_we    <= 1'b0;
            r_rw    <= 1'b0;
            r_dtw   <= '0;
            r_stb   <= 1'b0;
            r_cnt   <= '0;
            r_rdat  <= '0;
            r_terr  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_addr  <= w_addr;
            r_wdat  <= w_wdat;
            r_sel   <= w_sel;
            r_we    <= w_we;
            r_rw    <= w_rw;
            r_dtw   <= w_dtw;
            r_stb   <= w_stb;
            r_cnt   <= w_cnt;
            r_rdat  <= w_rdat;
            r_terr  <= w_terr;
        end
    end

    assign req         = (r_state != IDLE) && (r_state != DONE);
    assign wbs_ack_o   = (r_state == DONE) && wbs_cyc_i;
    assign wbs_dat_o   = r_rdat;
    assign addr        = r_addr;
    assign rw          = r_rw;
    assign dtw         = r_dtw;
    assign stb         = r_stb;
    assign timeout_err = r_terr;
endmodule

// File: tb/tb_hs32_wb_bridge.sv
// tb_hs32_wb_bridge: directed checks of the hs32 Wishbone bridge with a one-word responder model.
module tb_hs32_wb_bridge;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wbs_stb_i = 1'b0, wbs_cyc_i = 1'b0, wbs_we_i = 1'b0;
    logic [3:0]  wbs_sel_i = 4'h0;
    logic [31:0] wbs_dat_i = '0, wbs_adr_i = '0;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic        req, gnt = 1'b1, rw, stb, ack, timeout_err;
    logic [31:0] addr, dtw, dtr;

    int          errs = 0, checks = 0;
    logic [31:0] mem = '0;
    logic        resp_en = 1'b1, spur = 1'b0, pend;
    int          stb_n;
    logic [31:0] log_addr [8];
    logic [31:0] log_dtw [8];
    logic        log_rw [8];
    logic        req_seen;

    hs32_wb_bridge #(.TIMEOUT(8'd8)) dut (
        .clk(clk), .reset(reset),
        .wbs_stb_i(wbs_stb_i), .wbs_cyc_i(wbs_cyc_i), .wbs_we_i(wbs_we_i),
        .wbs_sel_i(wbs_sel_i), .wbs_dat_i(wbs_dat_i), .wbs_adr_i(wbs_adr_i),
        .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
        .req(req), .gnt(gnt), .addr(addr), .rw(rw), .dtw(dtw), .dtr(dtr),
        .stb(stb), .ack(ack), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // Responder: acks one cycle after each stb, returns mem on that ack
    initial begin
        ack = 1'b0; dtr = '0; pend = 1'b0; stb_n = 0;
        forever begin
            @(posedge clk); #2;
            ack  = pend | spur;
            dtr  = ack ? mem : 32'h0;
            pend = stb & resp_en;
            if (stb) begin
                log_addr[stb_n % 8] = addr;
                log_dtw[stb_n % 8]  = dtw;
                log_rw[stb_n % 8]   = rw;
                stb_n++;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic xfer(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                        input logic w, output int lat, output logic [31:0] rd);
        wbs_adr_i = a; wbs_dat_i = d; wbs_sel_i = s; wbs_we_i = w;
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
        lat = -1; rd = '0; req_seen = 1'b0;
        for (int k = 1; k <= 30 && lat < 0; k++) begin
            @(posedge clk); #1;
            if (req) req_seen = 1'b1;
            if (wbs_ack_o) begin lat = k; rd = wbs_dat_o; end
        end
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        int          lat, base, acks;
        logic [31:0] rd;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ack", {31'b0, wbs_ack_o}, 0);
        chk("rst_req", {31'b0, req}, 0);
        chk("rst_stb", {31'b0, stb}, 0);
        chk("rst_rw", {31'b0, rw}, 0);
        chk("rst_addr", addr, 0);
        chk("rst_dtw", dtw, 0);
        chk("rst_dat", wbs_dat_o, 0);
        chk("rst_terr", {31'b0, timeout_err}, 0);
        reset = 1'b0;
        @(posedge clk); #1;

        base = stb_n;
        xfer(32'h3000_0010, 32'hCAFE_BABE, 4'hF, 1'b1, lat, rd);
        chk("wr_lat", lat, 4);
        chk("wr_nstb", stb_n - base, 1);
        chk("wr_addr", log_addr[base % 8], 32'h10);
        chk("wr_rw", {31'b0, log_rw[base % 8]}, 1);
        chk("wr_dtw", log_dtw[base % 8], 32'hCAFE_BABE);
        chk("wr_datkeep", rd, 0);

        mem = 32'h1234_5678;
        base = stb_n;
        xfer(32'h3000_0020, 32'h0, 4'hF, 1'b0, lat, rd);
        chk("rd_lat", lat, 4);
        chk("rd_dat", rd, 32'h1234_5678);
        chk("rd_rw", {31'b0, log_rw[base % 8]}, 0);
        chk("rd_addr", log_addr[base % 8], 32'h20);

        base = stb_n;
        xfer(32'h3000_0030, 32'h5555_5555, 4'h0, 1'b1, lat, rd);
        chk("sel0_lat", lat, 2);
        chk("sel0_nstb", stb_n - base, 0);

        mem = 32'hAABB_CCDD;
        base = stb_n;
        xfer(32'h3000_0040, 32'h1122_3344, 4'b0101, 1'b1, lat, rd);
`ifdef HS32_WB_RMW_EN
        chk("rmw_lat", lat, 6);
        chk("rmw_nstb", stb_n - base, 2);
        chk("rmw_rw0", {31'b0, log_rw[base % 8]}, 0);
        chk("rmw_rw1", {31'b0, log_rw[(base + 1) % 8]}, 1);
        chk("rmw_dtw", log_dtw[(base + 1) % 8], 32'hAA22_CC44);
`else
        chk("rmw_lat", lat, 2);
        chk("rmw_nstb", stb_n - base, 0);
`endif

        gnt = 1'b0;
        base = stb_n;
        mem = 32'h0BAD_CAFE;
        fork
            xfer(32'h3000_0050, 32'h0, 4'hF, 1'b0, lat, rd);
            begin
                repeat (11) @(posedge clk);
                #1;
                chk("arb_req", {31'b0, req}, 1);
                chk("arb_nostb", stb_n - base, 0);
                gnt = 1'b1;
            end
        join
        chk("arb_lat", lat, 14);
        chk("arb_dat", rd, 32'h0BAD_CAFE);

        base = stb_n;
        xfer(32'h2000_0000, 32'h0, 4'hF, 1'b0, lat, rd);
        chk("oow_ack", lat, -1);
        chk("oow_req", {31'b0, req_seen}, 0);
        chk("oow_nstb", stb_n - base, 0);

        base = stb_n;
        wbs_adr_i = 32'h3000_0060; wbs_we_i = 1'b0; wbs_sel_i = 4'hF;
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
        acks = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (wbs_ack_o) acks++;
        end
        chk("drop_ack", acks, 0);
        chk("drop_nstb", stb_n - base, 1);
        chk("drop_idle", {31'b0, req}, 0);

        resp_en = 1'b0;
        xfer(32'h3000_0070, 32'h0, 4'hF, 1'b0, lat, rd);
        chk("to_lat", lat, 10);
        chk("to_dat", rd, 32'hFFFF_FFFF);
        chk("to_err", {31'b0, timeout_err}, 1);
        resp_en = 1'b1;

        spur = 1'b1;
        @(posedge clk); #1;
        spur = 1'b0;
        acks = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (wbs_ack_o || req) acks++;
        end
        chk("spur_quiet", acks, 0);
        chk("spur_err", {31'b0, timeout_err}, 1);

        mem = 32'h0BAD_F00D;
        xfer(32'h3000_0080, 32'h0, 4'hF, 1'b0, lat, rd);
        chk("post_lat", lat, 4);
        chk("post_dat", rd, 32'h0BAD_F00D);
        chk("post_err", {31'b0, timeout_err}, 1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/hs32_wb_bridge.md
Name: hs32_wb_bridge

Overview:
- Wishbone classic-cycle responder on the user-project Wishbone slave port.
- Lets the management SoC (Wishbone initiator) read and write the hs32 internal memory bus (MMIO/SRAM) by acting as a second initiator on that bus.
- Requests bus ownership from an external arbiter shared with the CPU.
- Performs read-modify-write for byte-masked writes, and times out responders that never ack.

Parameters:
- BASE_ADDR, 32'h3000_0000: Wishbone window base; match when wbs_adr_i[31:WIN_BITS] == BASE_ADDR[31:WIN_BITS].
- WIN_BITS, 24: window size is 2^WIN_BITS bytes.
- TIMEOUT, 255: cycles to wait for internal ack before forced completion (1..255, 8-bit counter).

Ports:
- clk  in  1  clock; also the Wishbone clock.
- reset  in  1  synchronous, active-high reset.
- wbs_stb_i  in  1  Wishbone strobe.
- wbs_cyc_i  in  1  Wishbone cycle.
- wbs_we_i  in  1  1 = write.
- wbs_sel_i  in  4  byte selects; bit i selects byte [8i+7:8i].
- wbs_dat_i  in  32  write data.
- wbs_adr_i  in  32  byte address.
- wbs_ack_o  out  1  one-cycle acknowledge.
- wbs_dat_o  out  32  read data; valid when wbs_ack_o = 1.
- req  out  1  internal bus request to the arbiter.
- gnt  in  1  arbiter grant.
- addr  out  32  internal address = {zeros, wbs_adr_i[WIN_BITS-1:2], 2'b00}.
- rw  out  1  internal direction, 1 = write.
- dtw  out  32  internal write data.
- dtr  in  32  internal read data; valid in the cycle ack = 1.
- stb  out  1  internal one-cycle strobe.
- ack  in  1  internal one-cycle acknowledge.
- timeout_err  out  1  sticky flag: a timeout has occurred.

Behaviour:
- Reset: all outputs 0; state IDLE; timeout counter 0.
- Reset mid-transaction abandons the transaction with no Wishbone ack.
- Request condition = wbs_cyc_i & wbs_stb_i & window match. Out-of-window requests are ignored: no ack, no req.
- Internal handshake: stb is a single-cycle pulse. addr, rw and dtw are held stable from the stb cycle until ack. ack may arrive at any later cycle.
- ack received while not in READ, RMW_RD or WRITE is ignored.
- States:
  - IDLE: on request, latch adr/dat/sel/we; assert req; go to WAIT_GNT.
  - WAIT_GNT: hold req; wait for gnt (no timeout here). When gnt is sampled high:
    - we & sel==4'hF: next cycle pulse stb with rw=1, dtw=latched data; go to WRITE.
    - we & sel==4'h0: no internal access; go to DONE.
    - we & partial sel: see Optional Feature.
    - !we: pulse stb with rw=0; go to READ.
  - READ: on ack, latch dtr into wbs_dat_o; go to DONE.
  - RMW_RD: on ack, merge: byte i = sel[i] ? wdata byte i : dtr byte i. Next cycle pulse stb with rw=1, dtw=merged word; go to WRITE.
  - WRITE: on ack, go to DONE.
  - DONE: deassert req. Assert wbs_ack_o for one cycle only if wbs_cyc_i is still 1; otherwise the abort is silent. Go to IDLE.
- Latency with gnt tied high and ack one cycle after stb:
  - request sampled at edge N; req=1 in cycle N+1; stb in cycle N+2; ack in cycle N+3; wbs_ack_o in cycle N+4.
  - An RMW write adds 2 cycles.
- Back-to-back: IDLE re-samples the request the cycle after DONE, so a held stb starts a new transaction.
- Timeout: counter clears on every stb pulse and increments in READ/RMW_RD/WRITE. On reaching TIMEOUT: set wbs_dat_o = 32'hFFFF_FFFF, set timeout_err (cleared only by reset), go to DONE.
- A late ack after a timeout is ignored.
- A gnt deassert after the transaction has started is ignored; the arbiter is required not to revoke while req is high.
- wbs_dat_o holds its last value outside ack; it is not updated on writes.

Optional Feature:
- Macro: HS32_WB_RMW_EN.
- Defined: partial-sel writes go WAIT_GNT -> (stb, rw=0) -> RMW_RD -> WRITE -> DONE, as above.
- Undefined: partial-sel writes do no internal access and go directly to DONE with ack; the RMW_RD state and merge logic are absent.

Test Plan:
- Full write: adr 0x3000_0010, dat 0xCAFEBABE, sel F, gnt=1, responder acks 1 cycle after stb -> one stb with addr 0x10, rw=1, dtw 0xCAFEBABE; wbs_ack_o 4 cycles after request.
- Read: adr 0x3000_0020, responder returns 0x12345678 -> stb with rw=0; wbs_dat_o 0x12345678 with wbs_ack_o.
- RMW (macro defined): memory word 0xAABBCCDD, write 0x11223344 with sel 4'b0101 -> read stb, then write stb with dtw 0xAA22CC44. Macro undefined -> no stb; ack still returned.
- Timeout: TIMEOUT=8, responder never acks -> wbs_ack_o 8 cycles after stb, dat 0xFFFFFFFF, timeout_err=1 and sticky; a later spurious ack is ignored.
- Arbitration: gnt held low 10 cycles -> req stays 1, no stb; stb in the cycle after gnt is sampled high.
- Out-of-window adr 0x2000_0000 -> no req, no ack. Then cyc dropped while in READ -> internal read completes, no wbs_ack_o, IDLE.
